// File: rtl/prime_pkg.sv
// Shared definitions for the 3-bit prime detector and anything that needs
// the same prime classification (scoreboards, neighbouring datapath blocks).
package prime_pkg;

    typedef logic [2:0] val3_t;

    // Bit v is set exactly when v is prime.
    localparam logic [7:0] PRIME_MASK3 = 8'b1010_1100;

    function automatic logic is_prime3(input val3_t v);
        return PRIME_MASK3[v];
    endfunction

endpackage

// File: rtl/prime_sat_counter.sv
// Generic saturating up-counter: counts inc pulses, holds at all-ones,
// cleared by a synchronous active-high reset.
module prime_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/is_prime_procedural.sv
// 3-bit prime decode of {c,b,a} with a registered copy of the result and a
// saturating count of the clock edges at which the value was prime.
module is_prime_procedural
    import prime_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c,
    input  logic             b,
    input  logic             a,
    output logic             prime,
    output logic             prime_q,
    output logic [CNT_W-1:0] prime_cnt
);

    val3_t v;
    logic  prime_d;

    assign v = {c, b, a};

    // Unknown inputs match no item and fall through to the default of 0.
    always_comb begin
        case (v)
            3'd0:    prime = 1'b0;
            3'd1:    prime = 1'b0;
            3'd2:    prime = 1'b1;
            3'd3:    prime = 1'b1;
            3'd4:    prime = 1'b0;
            3'd5:    prime = 1'b1;
            3'd6:    prime = 1'b0;
            3'd7:    prime = 1'b1;
            default: prime = 1'b0;
        endcase
    end

    always_comb begin
        prime_d = prime;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_q <= 1'b0;
        end else begin
            prime_q <= prime_d;
        end
    end

    prime_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (prime),
        .cnt (prime_cnt)
    );

endmodule

// File: tb/tb_is_prime_procedural.sv
// Bench for is_prime_procedural: table-driven decode, hand-written register
// and counter sequences, then randomized traffic against a behavioural model.
module tb_is_prime_procedural;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c = 1'b0;
    logic       b = 1'b0;
    logic       a = 1'b0;
    logic       prime8, prime2;
    logic       prime_q8, prime_q2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int  m_q   = 0;
    int  m_c8  = 0;
    int  m_c2  = 0;

    typedef struct {
        int v;
        int exp_prime;
    } dec_vec_t;

    dec_vec_t dec_tab [8];

    always #5 clk = ~clk;

    is_prime_procedural #(.CNT_W(8)) dut8 (
        .clk (clk), .rst (rst), .c (c), .b (b), .a (a),
        .prime (prime8), .prime_q (prime_q8), .prime_cnt (cnt8)
    );

    is_prime_procedural #(.CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .c (c), .b (b), .a (a),
        .prime (prime2), .prime_q (prime_q2), .prime_cnt (cnt2)
    );

    function automatic int ref_prime(input int v);
        return (v == 2 || v == 3 || v == 5 || v == 7) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_v(input int v);
        c = v[2];
        b = v[1];
        a = v[0];
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then check the registered outputs just after it.
    task automatic tick(input bit do_check);
        int v;
        @(posedge clk);
        v = {29'd0, c, b, a};
        if (rst) begin
            m_q = 0; m_c8 = 0; m_c2 = 0;
        end else begin
            m_q = ref_prime(v);
            if (m_q == 1) begin
                m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
            end
        end
        #1;
        if (do_check) begin
            check("model_prime_q", int'(prime_q8), m_q);
            check("model_cnt8", int'(cnt8), m_c8);
            check("model_cnt2", int'(cnt2), m_c2);
        end
    endtask

    initial begin
        int sat_exp [6];
        int v;

        dec_tab[0] = '{0, 0}; dec_tab[1] = '{1, 0};
        dec_tab[2] = '{2, 1}; dec_tab[3] = '{3, 1};
        dec_tab[4] = '{4, 0}; dec_tab[5] = '{5, 1};
        dec_tab[6] = '{6, 0}; dec_tab[7] = '{7, 1};
        sat_exp = '{1, 2, 3, 3, 3, 3};

        // Exhaustive decode, rst low, 10 ns apart
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_v(dec_tab[i].v);
            #10;
            check($sformatf("decode_v%0d", dec_tab[i].v), int'(prime8), dec_tab[i].exp_prime);
            check($sformatf("decode2_v%0d", dec_tab[i].v), int'(prime2), dec_tab[i].exp_prime);
        end

        // Reset for two edges
        @(negedge clk);
        rst = 1'b1;
        set_v(0);
        tick(1'b0);
        tick(1'b0);
        check("reset_prime_q", int'(prime_q8), 0);
        check("reset_cnt8", int'(cnt8), 0);
        check("reset_cnt2", int'(cnt2), 0);

        // Registered path: v=3 then v=4
        rst = 1'b0;
        set_v(3);
        tick(1'b1);
        check("reg_q_after_3", int'(prime_q8), 1);
        set_v(4);
        tick(1'b1);
        check("reg_q_after_4", int'(prime_q8), 0);

        // Counting: 2,5,6,7,0 after reset gives 3
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        foreach (sat_exp[i]) begin end
        set_v(2); tick(1'b1);
        set_v(5); tick(1'b1);
        set_v(6); tick(1'b1);
        set_v(7); tick(1'b1);
        set_v(0); tick(1'b1);
        check("count_seq", int'(cnt8), 3);

        // Saturation of the 2-bit instance with v=7 held
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        set_v(7);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            check($sformatf("sat_cnt2_%0d", i), int'(cnt2), sat_exp[i]);
        end

        // Reset mid-count
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        set_v(5);
        tick(1'b1);
        tick(1'b1);
        check("mid_cnt_before", int'(cnt8), 2);
        rst = 1'b1;
        #1;
        check("mid_prime_in_rst", int'(prime8), 1);
        tick(1'b1);
        check("mid_cnt_after_rst", int'(cnt8), 0);
        check("mid_q_after_rst", int'(prime_q8), 0);
        check("mid_prime_after_rst", int'(prime8), 1);
        rst = 1'b0;
        tick(1'b1);
        check("mid_cnt_resume", int'(cnt8), 1);
        check("mid_q_resume", int'(prime_q8), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            v = int'($urandom_range(0, 7));
            set_v(v);
            rst = ($urandom_range(0, 24) == 0);
            #1;
            check("rand_prime", int'(prime8), ref_prime(v));
            tick(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
